apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Converts a simple request/grant/response bus into APB3 initiator transactions. It drives the SETUP and ACCESS phases, waits on PREADY, and returns read data and error status. It is the initiator counterpart of the peripheral APB slaves (timer, event unit, GPIO), and lets a core-side or debug-side port reach those peripherals. A programmable PREADY-stall timeout guarantees that every accepted request completes.

Parameters:
APB_ADDR_WIDTH, 12, width of addr_i and PADDR (peripheral slaves are 4KB).
TIMEOUT_CYCLES, 16, number of consecutive ACCESS cycles with PREADY low before the bridge aborts; 0 disables the timeout. Legal range is 0..65535.

Ports:
HCLK  in  1  clock; all logic is on the rising edge.
HRESETn  in  1  asynchronous active-low reset.
req_i  in  1  request valid.
addr_i  in  APB_ADDR_WIDTH  request byte address.
we_i  in  1  1 = write, 0 = read.
wdata_i  in  32  write data.
gnt_o  out  1  request accepted when req_i && gnt_o.
rvalid_o  out  1  one-cycle response strobe.
rdata_o  out  32  read data, valid while rvalid_o is high.
err_o  out  1  error flag, valid while rvalid_o is high.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Behaviour:
- Clock and reset: one clock, HCLK. Reset is asynchronous, active-low, on HRESETn.
- Reset values: state IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rvalid_o, rdata_o, err_o and the timeout counter are all 0.
- gnt_o is combinational: gnt_o = (state == IDLE). It does not depend on req_i.
- IDLE:
  - On req_i && gnt_o, register addr_i, we_i and wdata_i into PADDR, PWRITE and PWDATA, then go to SETUP.
  - PSEL = PENABLE = 0 in IDLE.
- SETUP (exactly 1 cycle): PSEL = 1, PENABLE = 0. Clear the timeout counter. Go to ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1. PADDR, PWRITE and PWDATA stay stable from SETUP until the transfer ends.
  - PREADY = 1: the transfer completes this cycle.
    - Capture rdata_o = PRDATA for a read, or 0 for a write.
    - Capture err_o = PSLVERR.
    - Assert rvalid_o for exactly the next cycle and go to IDLE.
  - PREADY = 0, timeout disabled or counter < TIMEOUT_CYCLES-1: increment the counter and stay in ACCESS.
  - PREADY = 0 and counter == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): abort.
    - Next cycle: PSEL = PENABLE = 0, rvalid_o = 1, err_o = 1, rdata_o = 0; go to IDLE.
  - PREADY high in the final timeout cycle wins: the transfer completes normally, not as a timeout.
  - PSLVERR and PRDATA are ignored whenever PREADY = 0.
- Latency: request accepted at edge T; SETUP in cycle T+1; ACCESS in cycle T+2. With zero wait states, rvalid_o is high in cycle T+3. Each PREADY wait state adds one cycle.
- Back-to-back: gnt_o is high in the same cycle as rvalid_o, because the state is already IDLE. A new request can be accepted then, giving a 3-cycle issue interval with zero-wait slaves.
- Outside a transfer:
  - PADDR, PWRITE and PWDATA keep their last values in IDLE; there is no spurious toggling.
  - rdata_o and err_o are forced to 0 whenever rvalid_o = 0.
- Counter width: the timeout counter is 16 bits and never wraps. It saturates by construction because the abort fires at TIMEOUT_CYCLES-1.
- Reset mid-transfer:
  - HRESETn low drops PSEL, PENABLE and rvalid_o immediately (asynchronously).
  - The interrupted transfer produces no response after reset release.
- No requests are queued. req_i seen while gnt_o = 0 is not accepted; the requester must hold it until granted.

Test Plan:
1. Write with zero wait states: addr 0x004, wdata 0x0000_0009, PREADY tied 1 -> gnt_o at T; PSEL=1/PENABLE=0 at T+1; PSEL=1/PENABLE=1 with PADDR=0x004, PWRITE=1, PWDATA=9 at T+2; rvalid_o=1, err_o=0, rdata_o=0 at T+3.
2. Read with 3 wait states: PREADY low for 3 ACCESS cycles, PRDATA=0xDEAD_BEEF -> ACCESS lasts 4 cycles with PADDR stable; rvalid_o at T+6 with rdata_o=0xDEADBEEF.
3. Slave error: read with PREADY=1, PSLVERR=1 -> rvalid_o=1, err_o=1. PSLVERR=1 while PREADY=0 in a wait cycle has no effect.
4. Timeout, TIMEOUT_CYCLES=8, PREADY stuck 0 -> exactly 8 ACCESS cycles; then PSEL=0, rvalid_o=1, err_o=1, rdata_o=0; gnt_o=1. Repeat with PREADY=1 in the 8th ACCESS cycle -> normal completion with err_o=0.
5. Back-to-back: req_i held high with 4 writes to a zero-wait slave -> gnt_o pulses every 3 cycles; 4 rvalid_o pulses; PADDR sequence matches the request order.
6. Reset during ACCESS (PREADY=0), HRESETn low mid-cycle -> PSEL=PENABLE=0 before the next edge; no rvalid_o after release; the first post-reset request completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: request/grant/response port to APB3 initiator, with a PREADY-stall
// timeout so every accepted request produces exactly one response.
module apb_master_bridge #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      state;
  logic [15:0] cnt;
  logic        timeout;
  assign gnt_o   = state == IDLE;
  assign timeout = (TIMEOUT_CYCLES != 0) && cnt == CNT_LAST;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
    end else begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      case (state)
        IDLE: if (req_i) begin
          state  <= SETUP;
          PSEL   <= 1'b1;
          PADDR  <= addr_i;
          PWRITE <= we_i;
          PWDATA <= wdata_i;
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
          cnt     <= '0;
        end
        ACCESS: if (PREADY || timeout) begin
          // a PREADY in the last allowed cycle still completes normally
          state    <= IDLE;
          PSEL     <= 1'b0;
          PENABLE  <= 1'b0;
          rvalid_o <= 1'b1;
          rdata_o  <= PREADY && !PWRITE ? PRDATA : '0;
          err_o    <= PREADY ? PSLVERR : 1'b1;
        end else if (cnt != '1) cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized transfers against a cycle-count reference model of the bridge.
module tb_apb_master_bridge;
  localparam int AW = 12, TO = 8;
  logic          HCLK = 0, HRESETn = 0, req_i = 0, we_i = 0, PREADY = 0, PSLVERR = 0;
  logic [AW-1:0] addr_i = '0, PADDR, last_a = '0;
  logic [31:0]   wdata_i = '0, PRDATA = '0, rdata_o, PWDATA, last_d = '0;
  logic          gnt_o, rvalid_o, err_o, PWRITE, PSEL, PENABLE, last_w = 0;
  int            checks = 0, errors = 0;

  always #5 HCLK = ~HCLK;

  apb_master_bridge #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Issue one request at the current negedge and follow it cycle by cycle up to its response.
  // The slave raises PREADY in ACCESS cycle index 'waits'; beyond the timeout window it never does.
  task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                      input int waits, input logic [31:0] rd, input logic se);
    int          done;
    logic [31:0] exp_rd;
    logic        exp_err;
    done    = 3 + (waits < TO ? waits : TO - 1);
    exp_rd  = (waits < TO && !w) ? rd : 32'h0;
    exp_err = waits < TO ? se : 1'b1;
    chk("gnt_before_req", gnt_o, 1);
    req_i = 1; addr_i = a; we_i = w; wdata_i = d;
    last_a = a; last_w = w; last_d = d;
    @(negedge HCLK);
    for (int n = 1; n <= done; n++) begin
      chk("psel", PSEL, n < done);
      chk("penable", PENABLE, n >= 2 && n < done);
      chk("gnt", gnt_o, n == done);
      chk("rvalid", rvalid_o, n == done);
      chk("rdata", rdata_o, n == done ? exp_rd : 32'h0);
      chk("err", err_o, n == done ? exp_err : 1'b0);
      chk("paddr", PADDR, a);
      chk("pwrite", PWRITE, w);
      chk("pwdata", PWDATA, d);
      // requests while busy must be ignored, so keep poking random ones
      req_i = 1'($urandom); addr_i = AW'($urandom); we_i = 1'($urandom); wdata_i = $urandom;
      PREADY  = (n - 2 == waits);
      PRDATA  = PREADY ? rd : $urandom;
      PSLVERR = PREADY ? se : 1'($urandom);
      if (n < done) @(negedge HCLK);
    end
    PREADY = 0;
  endtask

  task automatic idle(input int c);
    req_i = 0;
    repeat (c) begin
      @(negedge HCLK);
      chk("idle_psel", PSEL, 0);
      chk("idle_rvalid", rvalid_o, 0);
      chk("idle_rdata", rdata_o, 0);
      chk("idle_err", err_o, 0);
      chk("idle_gnt", gnt_o, 1);
      chk("idle_paddr", PADDR, last_a);
      chk("idle_pwrite", PWRITE, last_w);
      chk("idle_pwdata", PWDATA, last_d);
    end
  endtask

  initial begin
    #1;
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_gnt", gnt_o, 1);
    @(negedge HCLK);
    HRESETn = 1;
    idle(2);
    xfer(12'h004, 1, 32'h9, 0, 32'h1234_5678, 0);
    idle(1);
    xfer(12'h010, 0, 32'h0, 3, 32'hDEAD_BEEF, 0);
    idle(1);
    xfer(12'h020, 0, 32'h0, 0, 32'hCAFE_F00D, 1);
    xfer(12'h024, 0, 32'h0, 2, 32'h0BAD_0BAD, 0);
    xfer(12'h028, 1, 32'h55, 2, 32'h0, 1);
    idle(1);
    xfer(12'h030, 0, 32'h0, TO, 32'h1111_2222, 0);
    xfer(12'h034, 1, 32'h77, TO + 3, 32'h0, 0);
    xfer(12'h038, 0, 32'h0, TO - 1, 32'h3333_4444, 0);
    idle(1);
    for (int i = 0; i < 4; i++) xfer(AW'(12'h100 + 4 * i), 1, 32'hA0 + i, 0, 32'h0, 0);
    idle(1);
    for (int i = 0; i < 40; i++) begin
      xfer(AW'($urandom), 1'($urandom), $urandom, $urandom_range(0, TO + 2), $urandom, 1'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    req_i = 1; addr_i = 12'h123; we_i = 0;
    @(negedge HCLK);
    req_i = 0;
    chk("mid_setup", PSEL, 1);
    repeat (2) @(negedge HCLK);
    chk("mid_access", PENABLE, 1);
    #2 HRESETn = 0;
    #1;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_rvalid", rvalid_o, 0);
    @(negedge HCLK);
    HRESETn = 1;
    last_a = '0; last_w = 0; last_d = '0;
    idle(4);
    xfer(12'h044, 0, 32'h0, 1, 32'h600D_600D, 0);
    idle(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
